// File: rtl/memory_access_stage.sv
// memory_access_stage: data-memory access stage with lane alignment, load extension and a 4-state FSM; MEMORY_STAGE_MISALIGN_TRAP_EN traps misaligned accesses
module memory_access_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL_MEMORY_STAGE,
  input  logic        CLEAR_MEMORY_STAGE,
  input  logic [4:0]  RD_ADDRESS_IN,
  input  logic [31:0] ALU_OUT_IN,
  input  logic [2:0]  DATA_CACHE_LOAD_IN,
  input  logic [1:0]  DATA_CACHE_STORE_IN,
  input  logic [31:0] DATA_CACHE_STORE_DATA_IN,
  input  logic        WRITE_BACK_MUX_SELECT_IN,
  input  logic        RD_WRITE_ENABLE_IN,
  output logic        DMEM_REQ_VALID,
  input  logic        DMEM_REQ_READY,
  output logic [31:0] DMEM_ADDR,
  output logic        DMEM_WRITE,
  output logic [3:0]  DMEM_BYTE_EN,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_RESP_VALID,
  input  logic [31:0] DMEM_RDATA,
  output logic [4:0]  RD_ADDRESS_OUT,
  output logic [31:0] RD_DATA_OUT,
  output logic        RD_WRITE_ENABLE_OUT,
  output logic        MEMORY_BUSY,
  output logic        MISALIGNED
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic is_load, is_store, mis, take;
  logic [1:0] off, off_q;
  logic [3:0] be_nx;
  logic [31:0] wdata_nx, ld_data, alu_q, hold_q;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [2:0] ld_q;
  logic [4:0] rd_q;
  logic we_q, wb_mem_q;
  assign DMEM_REQ_VALID = state == REQ;
  assign MEMORY_BUSY = state != IDLE;
  // decode the incoming op; a load wins over a simultaneous store
  always_comb begin
    off = ALU_OUT_IN[1:0];
    is_load = DATA_CACHE_LOAD_IN != 3'b000;
    is_store = !is_load && DATA_CACHE_STORE_IN != 2'b00;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    mis = (off[0] && (is_load ? (DATA_CACHE_LOAD_IN == 3'b010 || DATA_CACHE_LOAD_IN == 3'b101) : DATA_CACHE_STORE_IN == 2'b10)) ||
          (off != 2'b00 && (is_load ? DATA_CACHE_LOAD_IN == 3'b011 : DATA_CACHE_STORE_IN == 2'b11));
`else
    mis = 1'b0;
`endif
    take = !STALL_MEMORY_STAGE && !CLEAR_MEMORY_STAGE && (is_load || is_store) && !mis;
    be_nx = DATA_CACHE_STORE_IN == 2'b01 ? 4'b0001 << off :
            DATA_CACHE_STORE_IN == 2'b10 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_nx = DATA_CACHE_STORE_IN == 2'b01 ? {4{DATA_CACHE_STORE_DATA_IN[7:0]}} :
               DATA_CACHE_STORE_IN == 2'b10 ? {2{DATA_CACHE_STORE_DATA_IN[15:0]}} : DATA_CACHE_STORE_DATA_IN;
  end
  // pick the addressed lane from the returned word and extend it
  always_comb begin
    ld_byte = DMEM_RDATA[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    ld_data = ld_q == 3'b001 ? {{24{ld_byte[7]}}, ld_byte} :
              ld_q == 3'b100 ? {24'h0, ld_byte} :
              ld_q == 3'b010 ? {{16{ld_half[15]}}, ld_half} :
              ld_q == 3'b101 ? {16'h0, ld_half} : DMEM_RDATA;
  end
  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  end
  // next state: an issued access always runs to completion regardless of stall/clear
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (take) state_nx = REQ;
      REQ: if (DMEM_REQ_READY) state_nx = DMEM_WRITE ? IDLE : WAIT;
      WAIT: if (DMEM_RESP_VALID) state_nx = DONE;
      DONE: if (!STALL_MEMORY_STAGE) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // request fields, load hold register and write-back output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {DMEM_ADDR, DMEM_WRITE, DMEM_BYTE_EN, DMEM_WDATA} <= '0;
      {RD_ADDRESS_OUT, RD_DATA_OUT, RD_WRITE_ENABLE_OUT, MISALIGNED} <= '0;
      {ld_q, off_q, rd_q, we_q, wb_mem_q, alu_q, hold_q} <= '0;
    end else begin
      MISALIGNED <= 1'b0;
      if (state == IDLE && !STALL_MEMORY_STAGE) begin
        if (CLEAR_MEMORY_STAGE || is_load || is_store) {RD_ADDRESS_OUT, RD_DATA_OUT, RD_WRITE_ENABLE_OUT} <= '0;
        else {RD_ADDRESS_OUT, RD_DATA_OUT, RD_WRITE_ENABLE_OUT} <= {RD_ADDRESS_IN, ALU_OUT_IN, RD_WRITE_ENABLE_IN};
        MISALIGNED <= !CLEAR_MEMORY_STAGE && mis;
        if (take) begin
          DMEM_ADDR <= {ALU_OUT_IN[31:2], 2'b00};
          DMEM_WRITE <= is_store;
          DMEM_BYTE_EN <= is_store ? be_nx : 4'b0000;
          DMEM_WDATA <= is_store ? wdata_nx : 32'h0;
          {ld_q, off_q, rd_q, we_q, wb_mem_q, alu_q} <= {DATA_CACHE_LOAD_IN, off, RD_ADDRESS_IN, RD_WRITE_ENABLE_IN, WRITE_BACK_MUX_SELECT_IN, ALU_OUT_IN};
        end
      end
      if (state == WAIT && DMEM_RESP_VALID) hold_q <= wb_mem_q ? ld_data : alu_q;
      if (state == DONE && !STALL_MEMORY_STAGE) {RD_ADDRESS_OUT, RD_DATA_OUT, RD_WRITE_ENABLE_OUT} <= {rd_q, hold_q, we_q};
    end
  end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed checks of the memory access stage
module tb_memory_access_stage;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, clear = 1'b0;
  logic [4:0] rd_in;
  logic [31:0] alu_in, sdata, rdata;
  logic [2:0] ld;
  logic [1:0] st;
  logic wbsel, we_in, ready = 1'b0, resp = 1'b0;
  logic req_valid, dwrite, we_out, busy, misaligned;
  logic [31:0] daddr, wdata, rd_data;
  logic [3:0] be;
  logic [4:0] rd_out;
  int total = 0, fails = 0;
  memory_access_stage dut (
    .CLK(clk), .RST_N(rst_n), .STALL_MEMORY_STAGE(stall), .CLEAR_MEMORY_STAGE(clear),
    .RD_ADDRESS_IN(rd_in), .ALU_OUT_IN(alu_in), .DATA_CACHE_LOAD_IN(ld), .DATA_CACHE_STORE_IN(st),
    .DATA_CACHE_STORE_DATA_IN(sdata), .WRITE_BACK_MUX_SELECT_IN(wbsel), .RD_WRITE_ENABLE_IN(we_in),
    .DMEM_REQ_VALID(req_valid), .DMEM_REQ_READY(ready), .DMEM_ADDR(daddr), .DMEM_WRITE(dwrite),
    .DMEM_BYTE_EN(be), .DMEM_WDATA(wdata), .DMEM_RESP_VALID(resp), .DMEM_RDATA(rdata),
    .RD_ADDRESS_OUT(rd_out), .RD_DATA_OUT(rd_data), .RD_WRITE_ENABLE_OUT(we_out),
    .MEMORY_BUSY(busy), .MISALIGNED(misaligned)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_op(input logic [4:0] r, input logic [31:0] a, input logic [2:0] l, input logic [1:0] s,
                        input logic [31:0] d, input logic w, input logic e);
    {rd_in, alu_in, ld, st, sdata, wbsel, we_in} = {r, a, l, s, d, w, e};
  endtask
  task automatic load_seq(input string tag, input logic [31:0] a, input logic [2:0] l, input logic w,
                          input logic [31:0] rd_word, input logic [31:0] exp);
    set_op(5'd7, a, l, 2'b00, 32'h0, w, 1'b1);
    ready = 1'b1;
    step();
    chk({tag, ".valid"}, req_valid, 1);
    chk({tag, ".addr"}, daddr, {a[31:2], 2'b00});
    chk({tag, ".write"}, dwrite, 0);
    chk({tag, ".be"}, be, 0);
    chk({tag, ".we_bubble"}, we_out, 0);
    step();
    chk({tag, ".wait_busy"}, busy, 1);
    chk({tag, ".wait_valid"}, req_valid, 0);
    resp = 1'b1;
    rdata = rd_word;
    step();
    resp = 1'b0;
    rdata = 32'h0;
    chk({tag, ".done_busy"}, busy, 1);
    step();
    chk({tag, ".data"}, rd_data, exp);
    chk({tag, ".rd"}, rd_out, 7);
    chk({tag, ".we"}, we_out, 1);
    chk({tag, ".idle"}, busy, 0);
    set_op(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    set_op(0, 0, 0, 0, 0, 0, 0);
    rdata = 32'h0;
    @(negedge clk);
    chk("rst.valid", req_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.data", rd_data, 0);
    chk("rst.mis", misaligned, 0);
    chk("rst.be", be, 0);
    rst_n = 1'b1;
    set_op(5'd5, 32'h3, 0, 0, 0, 0, 1);
    step();
    chk("nop1.data", rd_data, 3);
    chk("nop1.rd", rd_out, 5);
    chk("nop1.we", we_out, 1);
    chk("nop1.busy", busy, 0);
    set_op(5'd6, 32'h11, 0, 0, 0, 0, 1);
    step();
    chk("nop2.data", rd_data, 32'h11);
    chk("nop2.rd", rd_out, 6);
    set_op(5'd5, 32'h3, 0, 0, 0, 0, 1);
    step();
    chk("nop3.data", rd_data, 3);
    chk("nop3.busy", busy, 0);
    stall = 1'b1;
    set_op(5'd9, 32'h55, 0, 0, 0, 0, 1);
    step();
    chk("stall_idle.data", rd_data, 3);
    chk("stall_idle.rd", rd_out, 5);
    stall = 1'b0;
    clear = 1'b1;
    step();
    chk("clear.data", rd_data, 0);
    chk("clear.we", we_out, 0);
    clear = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    load_seq("lb", 32'h1003, 3'b001, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80);
    load_seq("lbu", 32'h1003, 3'b100, 1'b1, 32'h80FF_0000, 32'h0000_0080);
    load_seq("lh", 32'h1002, 3'b010, 1'b1, 32'h80FF_0000, 32'hFFFF_80FF);
    load_seq("lhu", 32'h1000, 3'b101, 1'b1, 32'h1234_F00D, 32'h0000_F00D);
    load_seq("lw_alu", 32'h5000, 3'b011, 1'b0, 32'h1234_5678, 32'h0000_5000);
    set_op(5'd9, 32'h2002, 0, 2'b10, 32'h0000_BEEF, 0, 1);
    ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("sh.valid", req_valid, 1);
      chk("sh.addr", daddr, 32'h2000);
      chk("sh.write", dwrite, 1);
      chk("sh.be", be, 4'b1100);
      chk("sh.wdata", wdata, 32'hBEEF_BEEF);
      chk("sh.busy", busy, 1);
      chk("sh.we", we_out, 0);
      if (i == 2) ready = 1'b1;
      step();
    end
    chk("sh.end_busy", busy, 0);
    chk("sh.end_valid", req_valid, 0);
    chk("sh.end_we", we_out, 0);
    set_op(5'd9, 32'h2001, 0, 2'b01, 32'h1234_56AB, 0, 1);
    step();
    chk("sb.be", be, 4'b0010);
    chk("sb.wdata", wdata, 32'hABAB_ABAB);
    set_op(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("sb.idle", busy, 0);
    set_op(5'd3, 32'h4000, 3'b011, 0, 0, 1, 1);
    step();
    step();
    stall = 1'b1;
    clear = 1'b1;
    resp = 1'b1;
    rdata = 32'hCAFE_F00D;
    step();
    resp = 1'b0;
    clear = 1'b0;
    chk("lw_stall.done_busy", busy, 1);
    chk("lw_stall.held_data", rd_data, 0);
    step();
    chk("lw_stall.still_busy", busy, 1);
    chk("lw_stall.still_data", rd_data, 0);
    stall = 1'b0;
    step();
    chk("lw_stall.data", rd_data, 32'hCAFE_F00D);
    chk("lw_stall.rd", rd_out, 3);
    chk("lw_stall.busy", busy, 0);
    set_op(0, 0, 0, 0, 0, 0, 0);
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    set_op(5'd7, 32'h3001, 3'b011, 0, 0, 1, 1);
    step();
    chk("mis.valid", req_valid, 0);
    chk("mis.flag", misaligned, 1);
    chk("mis.busy", busy, 0);
    chk("mis.data", rd_data, 0);
    set_op(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("mis.pulse_end", misaligned, 0);
`else
    load_seq("lw_mis", 32'h3001, 3'b011, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("lw_mis.flag", misaligned, 0);
`endif
    set_op(5'd4, 32'h6000, 3'b011, 0, 0, 1, 1);
    ready = 1'b1;
    step();
    step();
    chk("rst_mid.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.valid", req_valid, 0);
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.addr", daddr, 0);
    chk("rst_mid.data", rd_data, 0);
    set_op(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_mid.idle", busy, 0);
    chk("rst_mid.we", we_out, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

- Pipeline stage that sits directly downstream of the execution stage in the RISC-V core.
- Consumes the execution stage's result bundle:
  - ALU result or effective address
  - load/store codes and store data
  - write-back select, destination register and write enable
- Performs data-memory accesses over a valid/ready request and response-valid port, with byte-lane alignment, load sign/zero extension and a 4-state FSM.
- Presents the write-back bundle to the write-back stage and raises a busy signal so upstream stages hold while a memory access is outstanding.

## Interface
Parameters: none.
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- STALL_MEMORY_STAGE  in  1  hold: no capture, outputs frozen
- CLEAR_MEMORY_STAGE  in  1  flush: capture a bubble instead of inputs (IDLE only)
- RD_ADDRESS_IN  in  5  destination register
- ALU_OUT_IN  in  32  ALU result / effective address
- DATA_CACHE_LOAD_IN  in  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU
- DATA_CACHE_STORE_IN  in  2  00 none, 01 SB, 10 SH, 11 SW
- DATA_CACHE_STORE_DATA_IN  in  32  rs2 value for stores
- WRITE_BACK_MUX_SELECT_IN  in  1  1 = write-back data from memory, 0 = ALU
- RD_WRITE_ENABLE_IN  in  1  register write enable
- DMEM_REQ_VALID  out  1  request valid
- DMEM_REQ_READY  in  1  memory accepts request
- DMEM_ADDR  out  32  {ALU_OUT_IN[31:2], 2'b00}
- DMEM_WRITE  out  1  1 = store
- DMEM_BYTE_EN  out  4  store lane enables; 4'b0000 for loads
- DMEM_WDATA  out  32  lane-replicated store data
- DMEM_RESP_VALID  in  1  load data valid, one-cycle pulse
- DMEM_RDATA  in  32  load word
- RD_ADDRESS_OUT  out  5  to write-back
- RD_DATA_OUT  out  32  to write-back
- RD_WRITE_ENABLE_OUT  out  1  to write-back
- MEMORY_BUSY  out  1  combinational: state != IDLE
- MISALIGNED  out  1  one-cycle misalignment flag

## Operation
- States:
  - IDLE
  - REQ: DMEM_REQ_VALID=1
  - WAIT: load response pending
  - DONE: load result held
- IDLE, STALL=0, CLEAR=1: output registers load a bubble (all zero).
- IDLE, STALL=0, non-memory op: RD_ADDRESS_OUT/RD_WRITE_ENABLE_OUT load inputs; RD_DATA_OUT=ALU_OUT_IN.
- IDLE, STALL=0, load or store: request fields captured; output bubble loaded; state→REQ.
- Upstream holds its inputs while MEMORY_BUSY=1; inputs are ignored outside IDLE.
- REQ: request fields are stable until DMEM_REQ_VALID && DMEM_REQ_READY.
  - Store handshake → IDLE.
  - Load handshake → WAIT.
- WAIT: DMEM_RESP_VALID captures the extracted word into a hold register → DONE. RESP_VALID in other states is ignored.
- DONE, STALL=0: output registers load {rd, hold data, we} → IDLE. With STALL=1 it stays in DONE.
- STALL and CLEAR do not affect REQ/WAIT; an issued access always completes.
- Load extraction, with off = ALU_OUT_IN[1:0]:
  - LB/LBU: byte at lane off, sign/zero-extended.
  - LH/LHU: half at off[1], sign/zero-extended.
  - LW: whole word.
- Store lanes:
  - SB: BYTE_EN = 1<<off, WDATA = byte ×4.
  - SH: BYTE_EN = off[1] ? 1100 : 0011, WDATA = half ×2.
  - SW: BYTE_EN = 1111.
- Load and store both nonzero is illegal; the load is executed.
- For a load with WRITE_BACK_MUX_SELECT_IN=0, RD_DATA_OUT = ALU_OUT_IN.

## Timing
- Reset: state IDLE; every output, including DMEM_* and MISALIGNED, is 0.
- Assertion mid-transaction abandons the transaction immediately; the memory is reset by the same RST_N.
- Non-memory op accepted at edge N: outputs valid after edge N. Throughput is one per cycle.
- Load accepted at edge N, READY=1 at edge N+1, RESP_VALID at edge N+2: result on outputs after edge N+3. MEMORY_BUSY is high for 3 cycles.
- Store with immediate READY: MEMORY_BUSY is high for 1 cycle (REQ); the output is a bubble.
- Each READY=0 or missing RESP_VALID cycle adds exactly one cycle.
- Output registers hold their value while STALL=1 in IDLE or DONE; otherwise they present bubbles during REQ/WAIT.

## Configuration
- MEMORY_STAGE_MISALIGN_TRAP_EN defined:
  - A misaligned access is detected at IDLE capture: LH/LHU/SH with off[0]=1, or LW/SW with off≠0.
  - No request is issued and the state stays IDLE.
  - The outputs load a bubble, and MISALIGNED=1 for the following cycle.
- Undefined:
  - MISALIGNED is tied to 0.
  - Ignored low address bits are dropped: halfword uses off[1], word ignores off.
  - The access proceeds normally.

## Test plan
- Non-memory ops with ALU_OUT_IN=0x00000003, rd=5, we=1, three back-to-back → RD_DATA_OUT=3, rd=5 one cycle after each capture; MEMORY_BUSY stays 0.
- LB at address 0x1003, RDATA=0x80FF_0000, READY and RESP immediate:
  - DMEM_ADDR=0x1000
  - 3 cycles later RD_DATA_OUT=0xFFFFFF80
  - LBU at the same address → 0x00000080
- SH at address 0x2002, store data 0x0000BEEF, READY held low 2 cycles:
  - VALID/ADDR/BYTE_EN=1100/WDATA=0xBEEFBEEF stable throughout
  - MEMORY_BUSY high 3 cycles; RD_WRITE_ENABLE_OUT=0
- LW with response arriving while STALL=1 → result held in DONE; it appears one cycle after STALL drops. CLEAR asserted in WAIT has no effect.
- LW at 0x3001:
  - With the macro: no DMEM_REQ_VALID, MISALIGNED pulses once.
  - Without: DMEM_ADDR=0x3000, normal completion.
- RST_N low during WAIT → DMEM_REQ_VALID and all outputs 0 immediately; state IDLE after release.
